// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver: per-frame input snapshot, prescaled digit scan.
// Optional leading-zero blanking is enabled by defining SEG7_SCAN_LZB_EN.
module seg7_scan_mux #(
  parameter int DIGITS     = 4,
  parameter int PRESCALE   = 100000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_POL   = {DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]        SEG_POL  = {7{ACTIVE_LOW}};

  // Logical segment pattern, bit order g..a; codes 10..15 are dark.
  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b0111111;
      4'd1:    decode = 7'b0000110;
      4'd2:    decode = 7'b1011011;
      4'd3:    decode = 7'b1001111;
      4'd4:    decode = 7'b1100110;
      4'd5:    decode = 7'b1101101;
      4'd6:    decode = 7'b1111101;
      4'd7:    decode = 7'b0000111;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1101111;
      default: decode = 7'b0000000;
    endcase
  endfunction

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_nxt;
  logic                tick;
  logic                wrap;

  logic [4*DIGITS-1:0] sh_digits;
  logic [DIGITS-1:0]   sh_dp;
  logic [DIGITS-1:0]   sh_blank;
  logic [4*DIGITS-1:0] load_digits;

  logic [4*DIGITS-1:0] src_digits;
  logic [DIGITS-1:0]   src_dp;
  logic [DIGITS-1:0]   src_blank;
  logic [3:0]          cur_digit;
  logic                cur_blank;
  logic [DIGITS-1:0]   an_nxt;
  logic [6:0]          seg_nxt;
  logic                dp_nxt;

  assign tick    = (cnt == CNT_LAST);
  assign wrap    = tick && (idx == IDX_LAST);
  assign idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;

`ifdef SEG7_SCAN_LZB_EN
  logic lz_seen;

  // Digits above the most-significant nonzero one are replaced by the dark code;
  // their dp bits are untouched, and digit 0 is never suppressed.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    load_digits = digits_in;
    lz_seen     = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz_seen = lz_seen | (digits_in[4*i +: 4] != 4'd0);
      if (!lz_seen) load_digits[4*i +: 4] = 4'hF;
    end
  end
`else
  assign load_digits = digits_in;
`endif

  // On a wrap the digit about to be lit must come from the values being snapshotted.
  always_comb begin
    src_digits = wrap ? load_digits : sh_digits;
    src_dp     = wrap ? dp_in       : sh_dp;
    src_blank  = wrap ? blank_in    : sh_blank;
    cur_digit  = src_digits[4*int'(idx_nxt) +: 4];
    cur_blank  = src_blank[idx_nxt];
    an_nxt          = '0;
    an_nxt[idx_nxt] = 1'b1;
    seg_nxt    = cur_blank ? 7'b0000000 : decode(cur_digit);
    dp_nxt     = src_dp[idx_nxt] && !cur_blank;
  end

  // Reset parks the scan at the last digit with a pending tick, so the first
  // active edge is a wrap that snapshots the inputs and lights digit 0.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      cnt <= CNT_LAST;
      idx <= IDX_LAST;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= idx_nxt;
    end
  end

  // NOTE: the shadow registers are reset on purpose so the first frame starts from a known dark state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_digits <= {DIGITS{4'hF}};
      sh_dp     <= '0;
      sh_blank  <= '1;
    end else if (wrap) begin
      sh_digits <= load_digits;
      sh_dp     <= dp_in;
      sh_blank  <= blank_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an          <= AN_POL;
      seg         <= SEG_POL;
      dp          <= ACTIVE_LOW;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (tick) begin
        an  <= an_nxt ^ AN_POL;
        seg <= seg_nxt ^ SEG_POL;
        dp  <= dp_nxt ^ ACTIVE_LOW;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux (DIGITS=4, PRESCALE=4, active-low pins) against a
// frame/slot arithmetic reference model; follows SEG7_SCAN_LZB_EN like the design.
module tb_seg7_scan_mux;

  localparam int D  = 4;
  localparam int P  = 4;
  localparam int FR = D * P;
  localparam logic [6:0] DEC_TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
  };
  localparam logic [12:0] IDLE = 13'h1FFE;  // an=1111, seg=7F, dp=1, frame_start=0

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   digits_in = '0;
  logic [3:0]    dp_in = '0;
  logic [3:0]    blank_in = '0;
  logic [3:0]    an;
  logic [6:0]    seg;
  logic          dp;
  logic          frame_start;

  int compared   = 0;
  int mismatched = 0;

  seg7_scan_mux #(.DIGITS(D), .PRESCALE(P), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .blank_in(blank_in),
    .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Reference model: n counts active edges since reset; a snapshot is taken at the
  // first edge of every frame, and the lit digit is simply ((n-1)/P) mod D.
  int          n = 0;
  logic [15:0] s_dig = 16'hFFFF;
  logic [3:0]  s_dp = '0;
  logic [3:0]  s_blank = '1;

  always @(posedge clk) begin
    if (rst) begin
      n = 0; s_dig = 16'hFFFF; s_dp = '0; s_blank = '1;
    end else begin
      n = n + 1;
      if ((n - 1) % FR == 0) begin
        s_dig = digits_in; s_dp = dp_in; s_blank = blank_in;
      end
    end
  end

  function automatic logic [12:0] expected();
    int d, msd;
    logic [6:0] s;
    logic p, fs;
    logic [3:0] a;
    if (n == 0) return IDLE;
    d  = ((n - 1) / P) % D;
    fs = ((n - 1) % FR == 0);
    msd = 0;
    for (int i = 0; i < D; i++) if (s_dig[4*i +: 4] != 4'd0) msd = i;
    s = s_blank[d] ? 7'h00 : DEC_TBL[s_dig[4*d +: 4]];
`ifdef SEG7_SCAN_LZB_EN
    if (d > msd) s = 7'h00;
`endif
    p = s_dp[d] && !s_blank[d];
    a = 4'b0001 << d;
    return {~a, ~s, ~p, fs};
  endfunction

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] exp;
    rst = 1'b1; digits_in = 16'h1234; dp_in = '0; blank_in = '0;
    repeat (3) begin
      @(negedge clk); compared++;
      if ({an, seg, dp, frame_start} !== IDLE) begin
        mismatched++;
        $display("FAIL reset_hold got=%h exp=%h", {an, seg, dp, frame_start}, IDLE);
      end
    end
    rst = 1'b0;
    #1; compared++;
    if ({an, seg, dp, frame_start} !== IDLE) begin
      mismatched++;
      $display("FAIL reset_cycle1 got=%h exp=%h", {an, seg, dp, frame_start}, IDLE);
    end
    @(negedge clk); compared++;
    if (an !== 4'b1110 || frame_start !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_cycle2 an=%b fs=%b exp an=1110 fs=1", an, frame_start);
    end
    exp = expected(); compared++;
    if ({an, seg, dp, frame_start} !== exp) begin
      mismatched++;
      $display("FAIL reset_model n=%0d got=%h exp=%h", n, {an, seg, dp, frame_start}, exp);
    end
  endtask

  task automatic test_scan();
    logic [12:0] exp;
    int pulses = 0;
    repeat (40) begin
      @(negedge clk);
      exp = expected(); compared++;
      if ({an, seg, dp, frame_start} !== exp) begin
        mismatched++;
        $display("FAIL scan n=%0d got=%h exp=%h", n, {an, seg, dp, frame_start}, exp);
      end
      if (frame_start) pulses++;
      if (n == 5) begin
        compared++;
        if (an !== 4'b1101 || seg !== 7'h30) begin
          mismatched++;
          $display("FAIL scan_digit1 an=%b seg=%h exp an=1101 seg=30", an, seg);
        end
      end
    end
    compared++;
    if (pulses != 2) begin
      mismatched++;
      $display("FAIL scan_frame_pulses got=%0d exp=2", pulses);
    end
  endtask

  task automatic test_snapshot();
    logic [12:0] exp;
    digits_in = 16'h1234; dp_in = '0; blank_in = '0;
    do_reset();
    repeat (40) begin
      @(negedge clk);
      exp = expected(); compared++;
      if ({an, seg, dp, frame_start} !== exp) begin
        mismatched++;
        $display("FAIL snapshot n=%0d got=%h exp=%h", n, {an, seg, dp, frame_start}, exp);
      end
      if (n == 9 || n == 17) begin
        compared++;
        if (seg !== ((n == 9) ? 7'h24 : 7'h00)) begin
          mismatched++;
          $display("FAIL snapshot_digit n=%0d seg=%h exp=%h", n, seg, (n == 9) ? 7'h24 : 7'h00);
        end
      end
      if (n == 6) digits_in = 16'h5678;
    end
  endtask

  task automatic test_decode_blank();
    logic [12:0] exp;
    digits_in = 16'hFA09; blank_in = 4'b0001; dp_in = 4'b0011;
    do_reset();
    repeat (20) begin
      @(negedge clk);
      exp = expected(); compared++;
      if ({an, seg, dp, frame_start} !== exp) begin
        mismatched++;
        $display("FAIL decode_blank n=%0d got=%h exp=%h", n, {an, seg, dp, frame_start}, exp);
      end
      if (n == 1 || n == 5) begin
        compared++;
        if ({seg, dp} !== ((n == 1) ? 8'hFF : 8'h80)) begin
          mismatched++;
          $display("FAIL decode_blank_digit n=%0d seg_dp=%h exp=%h", n, {seg, dp}, (n == 1) ? 8'hFF : 8'h80);
        end
      end
    end
  endtask

  task automatic test_lzb();
    logic [12:0] exp;
    logic [6:0] exp_seg;
    digits_in = 16'h0042; blank_in = '0; dp_in = '0;
    do_reset();
    repeat (36) begin
      @(negedge clk);
      exp = expected(); compared++;
      if ({an, seg, dp, frame_start} !== exp) begin
        mismatched++;
        $display("FAIL lzb n=%0d got=%h exp=%h", n, {an, seg, dp, frame_start}, exp);
      end
`ifdef SEG7_SCAN_LZB_EN
      exp_seg = 7'h7F;
`else
      exp_seg = 7'h40;
`endif
      if (n == 13) begin
        compared++;
        if (seg !== exp_seg) begin
          mismatched++;
          $display("FAIL lzb_digit3 seg=%h exp=%h", seg, exp_seg);
        end
      end
      if (n == 10) digits_in = 16'h0000;
    end
  endtask

  task automatic test_mid_reset();
    logic [12:0] exp;
    digits_in = 16'h9087; dp_in = 4'b1010; blank_in = '0;
    do_reset();
    while (n != 10) @(negedge clk);
    rst = 1'b1;
    digits_in = 16'h3141;
    @(negedge clk); compared++;
    if ({an, seg, dp, frame_start} !== IDLE) begin
      mismatched++;
      $display("FAIL mid_reset_idle got=%h exp=%h", {an, seg, dp, frame_start}, IDLE);
    end
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      exp = expected(); compared++;
      if ({an, seg, dp, frame_start} !== exp) begin
        mismatched++;
        $display("FAIL mid_reset n=%0d got=%h exp=%h", n, {an, seg, dp, frame_start}, exp);
      end
      if (n == 1) begin
        compared++;
        if (an !== 4'b1110 || frame_start !== 1'b1 || seg !== 7'h79) begin
          mismatched++;
          $display("FAIL mid_reset_restart an=%b fs=%b seg=%h exp an=1110 fs=1 seg=79", an, frame_start, seg);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [12:0] exp;
    do_reset();
    repeat (600) begin
      @(negedge clk);
      exp = expected(); compared++;
      if ({an, seg, dp, frame_start} !== exp) begin
        mismatched++;
        $display("FAIL random n=%0d rst=%b got=%h exp=%h", n, rst, {an, seg, dp, frame_start}, exp);
      end
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 149) == 0) rst = 1'b1;
      if ($urandom_range(0, 5) == 0) begin
        for (int i = 0; i < D; i++) digits_in[4*i +: 4] = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 2) == 0) digits_in[15:8] = 8'h00;
        dp_in    = 4'($urandom);
        blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_snapshot();
    test_decode_blank();
    test_lzb();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
